// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared comms definitions for the UART receiver
package uart_rx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_START   = 3'd1,
      ST_DATA    = 3'd2,
      ST_STOP    = 3'd3,
      ST_WAIT_HI = 3'd4
   } rx_state_t;

   localparam int         OVS_DEFAULT = 16;
   localparam logic [3:0] NBITS_MIN   = 4'd5;
   localparam logic [3:0] NBITS_MAX   = 4'd8;

   // Out-of-range frame widths fall back to a full byte.
   function automatic logic [3:0] clamp_nbits(input logic [3:0] n);
      return ((n < NBITS_MIN) || (n > NBITS_MAX)) ? NBITS_MAX : n;
   endfunction

endpackage

// File: rtl/rx_sync2.sv
// rtl/rx_sync2.sv - two-flop synchroniser for an idle-high asynchronous input
module rx_sync2 (
   input  logic clock,
   input  logic reset,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver, 5..8 data bits, one stop bit
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int OVS = OVS_DEFAULT,
   parameter int DW  = 8
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          Tick,
   input  logic [3:0]    N_bits,
   input  logic          Rx_in,
   output logic [DW-1:0] Data_out,
   output logic          Rx_done,
   output logic          Frame_err,
   output logic          Busy
);

   localparam int            SW     = $clog2(OVS);
   localparam logic [SW-1:0] S_MID  = SW'(OVS / 2 - 1);
   localparam logic [SW-1:0] S_LAST = SW'(OVS - 1);

   logic          rx_s;
   rx_state_t     state_q;
   logic [SW-1:0] s_q;
   logic [2:0]    n_q;
   logic [3:0]    nb_q;
   logic [DW-1:0] sh_q;
   logic [DW-1:0] data_q;
   logic          done_q;
   logic          err_q;

   logic [3:0]    nb_d;
   logic [DW-1:0] aligned_d;
   logic          last_bit_d;

   rx_sync2 u_sync (
      .clock (clock),
      .reset (reset),
      .d_i   (Rx_in),
      .q_o   (rx_s)
   );

   assign nb_d       = clamp_nbits(N_bits);
   // Bits enter at the MSB, so a short frame sits in the top nb bits of sh.
   assign aligned_d  = sh_q >> (DW - int'(nb_q));
   assign last_bit_d = ({1'b0, n_q} == (nb_q - 4'd1));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         s_q     <= '0;
         n_q     <= '0;
         nb_q    <= NBITS_MAX;
         sh_q    <= '0;
         data_q  <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (!rx_s) begin
                  state_q <= ST_START;
                  s_q     <= '0;
               end
            end
            ST_START: begin
               if (Tick) begin
                  s_q <= s_q + 1'b1;
                  if (s_q == S_MID) begin
                     if (!rx_s) begin
                        state_q <= ST_DATA;
                        s_q     <= '0;
                        n_q     <= '0;
                        nb_q    <= nb_d;
                     end else begin
                        state_q <= ST_IDLE;
                     end
                  end
               end
            end
            ST_DATA: begin
               if (Tick) begin
                  s_q <= s_q + 1'b1;
                  if (s_q == S_LAST) begin
                     sh_q <= {rx_s, sh_q[DW-1:1]};
                     s_q  <= '0;
                     if (last_bit_d) begin
                        state_q <= ST_STOP;
                     end else begin
                        n_q <= n_q + 3'd1;
                     end
                  end
               end
            end
            ST_STOP: begin
               if (Tick) begin
                  s_q <= s_q + 1'b1;
                  if (s_q == S_LAST) begin
                     data_q  <= aligned_d;
                     done_q  <= 1'b1;
                     err_q   <= ~rx_s;
                     state_q <= rx_s ? ST_IDLE : ST_WAIT_HI;
                  end
               end
            end
            ST_WAIT_HI: begin
               if (rx_s) begin
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign Data_out  = data_q;
   assign Rx_done   = done_q;
   assign Frame_err = err_q;
   assign Busy      = (state_q != ST_IDLE);

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver: the receive-side counterpart of the UART transmitter in the comms path. It deserialises an asynchronous 8N1-style line (5–8 data bits, LSB first, one start bit, one stop bit) using the shared 16x oversampling tick from the baud-rate generator. Each frame is presented as a parallel byte with a one-cycle done strobe and a framing-error flag. It runs from the same `clock` and `Tick` source as the transmitter, so one baud setting serves both directions.

## Interface
Parameters:
- `OVS`, 16: tick pulses per bit period. Must be a power of two, ≥ 8.
- `DW`, 8: maximum data width and width of `Data_out`.

Ports:
- `clock`  in  1  system clock; all flops rise-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `Tick`  in  1  one-cycle oversampling pulse from the baud-rate generator, OVS per bit.
- `N_bits`  in  4  data bits per frame, valid 5..8. Values outside this range are treated as 8. Sampled at start-bit confirmation.
- `Rx_in`  in  1  serial line, idle high, asynchronous to `clock`.
- `Data_out`  out  DW  last received word, right-aligned, unused upper bits 0.
- `Rx_done`  out  1  one-cycle pulse per completed frame.
- `Frame_err`  out  1  one-cycle pulse, coincident with `Rx_done`, when the stop bit samples low.
- `Busy`  out  1  high in any state other than IDLE.

## Operation
- `Rx_in` passes through a 2-flop synchroniser (`rx_s`). All decisions use `rx_s`. Both synchroniser flops reset to 1.
- Registers:
  - `state`.
  - tick counter `s` (log2 OVS bits).
  - bit counter `n` (3 bits).
  - latched width `nb`.
  - shift register `sh` (DW bits).
- State machine:
  - IDLE: on any clock with `rx_s`==0, go to START and clear `s`.
  - START: on each `Tick`, increment `s`. At the `Tick` where `s`==OVS/2−1:
    - if `rx_s`==0, go to DATA, clear `s` and `n`, latch `nb`.
    - else (glitch), return to IDLE. No strobe.
  - DATA: on each `Tick`, increment `s`. At the `Tick` where `s`==OVS−1:
    - shift `rx_s` into the MSB of `sh`, shifting right, and clear `s`.
    - if `n`==`nb`−1, go to STOP; else increment `n`.
  - STOP: at the `Tick` where `s`==OVS−1, sample `rx_s`:
    - high: load `Data_out`, pulse `Rx_done`, go to IDLE.
    - low: load `Data_out`, pulse `Rx_done` and `Frame_err`, go to WAIT_HI.
  - WAIT_HI: stay until `rx_s`==1, then go to IDLE. This covers line break / stuck-low and prevents a false restart.
- Alignment: `Data_out` = `sh` >> (DW−`nb`). LSB of `Data_out` is the first data bit received.
- Non-tick cycles hold `s`, `n`, `sh`. Only the IDLE start detection and WAIT_HI act on every clock.
- `N_bits` changes mid-frame have no effect; `nb` is latched once per frame.

## Timing
- Reset values:
  - `Data_out`=0, `Rx_done`=0, `Frame_err`=0, `Busy`=0.
  - state IDLE, `s`=`n`=0, `sh`=0.
  - synchroniser flops = 1.
- Reset mid-frame: abort immediately to IDLE, no strobe, `Data_out` cleared.
- Start detect latency: 2 clocks (synchroniser) plus 1 clock into START.
- Sample points: start-bit middle at OVS/2 ticks after detect; each data bit and the stop bit OVS ticks later.
- `Rx_done`/`Frame_err`: registered, high exactly one clock, on the clock after the stop-sample `Tick`. `Data_out` updates on that same edge and holds until the next frame completes.
- Frame length (N data bits): start detect to `Rx_done` ≈ (N+1)·OVS + OVS/2 ticks. The receiver is back in IDLE before the stop bit ends, so back-to-back frames are accepted.
- A new start edge arriving while `Rx_done` pulses is detected normally.

## Structure
- Shared comms package holds:
  - state encoding constants (IDLE, START, DATA, STOP, WAIT_HI; 3 bits);
  - the default OVS=16;
  - N_bits bounds (5, 8).
- Sub-module `rx_sync2`: 2-flop synchroniser with reset value 1, reusable for other async inputs.
- FSM, counters and shift register stay in one module.
- The transmitter-to-receiver loopback top is a separate testbench, not part of this block.

## Test plan
Common setup: 10 ns clock; baud-rate generator with divisor 54 driving `Tick`; one bit = 864 clocks.
- Loopback: UART transmitter sends 8'h75, then 8'h52, `N_bits`=8, `Rx_in` = transmitter output → `Rx_done` pulses twice, `Data_out` = 8'h75 then 8'h52, `Frame_err`=0.
- `N_bits`=5, line drives 5'b10110 LSB first → `Data_out`=8'h16, single `Rx_done`.
- Stop bit held low, then line low for 3 bit times → one `Rx_done` + `Frame_err` pulse; `Busy` stays high (WAIT_HI) until the line returns high; no second frame is decoded.
- 200-clock low glitch on an idle line → no `Rx_done`; `Busy` returns low before the START sample completes.
- Assert `reset` in the middle of data bit 4 → outputs return to 0 immediately. The next clean frame 8'hA5 is received correctly.
- Back-to-back frames 8'h00, 8'hFF with zero idle time → both received, `Rx_done` pulses 10 bit periods apart.
